// File: rtl/egress_packet_buffer.sv
// Store-and-forward egress buffer that sits after read_arbiter.
// It requests one packet at a time from the arbiter, and only when a maximum-length
// packet is sure to fit. Each word is stored as {sop, eop, data}. Whole packets are
// released on a valid/ready port, and never before their eop word has been written.
module egress_packet_buffer #(
  parameter int ARBITER_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH         = 32,
  parameter int FIFO_PTR_WIDTH     = 5,
  parameter int MAX_PACKET_WORDS   = 16,
  parameter int WAIT_TIMEOUT       = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ARBITER_DATA_WIDTH-1:0] rd_data,
  input  logic                          rd_sop,
  input  logic                          rd_vld,
  input  logic                          rd_eop,
  output logic                          ready,
  output logic [ARBITER_DATA_WIDTH-1:0] out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_vld,
  input  logic                          out_ready,
  output logic [FIFO_PTR_WIDTH:0]       pkt_count,
  output logic                          err
);

  localparam int ENTRY_W = ARBITER_DATA_WIDTH + 2;
  localparam int CNT_W   = FIFO_PTR_WIDTH + 1;
  localparam int WCNT_W  = $clog2(MAX_PACKET_WORDS + 1);
  localparam int TMO_W   = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_SOP = 3'd2,
    RECV     = 3'd3,
    DROP     = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          occ_q, occ_d;
  logic [CNT_W-1:0]          pkt_q, pkt_d;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      ready_q, ready_d;
  logic                      err_q, err_d;
  logic [ENTRY_W-1:0]        mem_q [FIFO_DEPTH];

  logic [CNT_W-1:0]   free_s;
  logic               wr_en_s, wr_sop_s, wr_eop_s, pkt_inc_s;
  logic               rd_en_s, pkt_dec_s;
  logic [ENTRY_W-1:0] head_s;

  // Head-of-FIFO word and read-side handshake
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    out_data  = head_s[ARBITER_DATA_WIDTH-1:0];
    out_eop   = head_s[ARBITER_DATA_WIDTH];
    out_sop   = head_s[ARBITER_DATA_WIDTH+1];
    out_vld   = (pkt_q != {CNT_W{1'b0}});
    rd_en_s   = out_vld & out_ready;
    pkt_dec_s = rd_en_s & head_s[ARBITER_DATA_WIDTH];
    free_s    = CNT_W'(FIFO_DEPTH) - occ_q;
    pkt_count = pkt_q;
    ready     = ready_q;
    err       = err_q;
  end

  // Request/receive FSM: next state, write strobes and the word and timeout counters
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    wr_en_s   = 1'b0;
    wr_sop_s  = 1'b0;
    wr_eop_s  = 1'b0;
    pkt_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (free_s >= CNT_W'(MAX_PACKET_WORDS)) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d = WAIT_SOP;
        tmo_d   = {TMO_W{1'b0}};
      end
      WAIT_SOP: begin
        if (rd_vld && rd_sop) begin
          wr_en_s  = 1'b1;
          wr_sop_s = 1'b1;
          wr_eop_s = rd_eop;
          wcnt_d   = WCNT_W'(1);
          if (rd_eop) begin
            pkt_inc_s = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = RECV;
          end
        end else begin
          // A stray word without sop is dropped but still counts toward the timeout
          if (rd_vld) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(WAIT_TIMEOUT - 1)) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_SOP;
          end
        end
      end
      RECV: begin
        if (rd_vld) begin
          // A second sop inside a packet is stored as plain data
          wr_en_s  = 1'b1;
          wr_sop_s = 1'b0;
          if (rd_sop) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (rd_eop) begin
            wr_eop_s  = 1'b1;
            pkt_inc_s = 1'b1;
            state_d   = IDLE;
          end else if (wcnt_q == WCNT_W'(MAX_PACKET_WORDS - 1)) begin
            // Overlength: close the packet at the cap, discard the remainder
            wr_eop_s  = 1'b1;
            pkt_inc_s = 1'b1;
            err_d     = 1'b1;
            state_d   = DROP;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else begin
          state_d = RECV;
        end
      end
      DROP: begin
        if (rd_vld && rd_eop) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == REQ);
  end

  // Pointer, occupancy and packet-count bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en_s ? FIFO_PTR_WIDTH'(1) : FIFO_PTR_WIDTH'(0));
    rd_ptr_d = rd_ptr_q + (rd_en_s ? FIFO_PTR_WIDTH'(1) : FIFO_PTR_WIDTH'(0));
    case ({wr_en_s, rd_en_s})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    case ({pkt_inc_s, pkt_dec_s})
      2'b10:   pkt_d = pkt_q + CNT_W'(1);
      2'b01:   pkt_d = pkt_q - CNT_W'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= {FIFO_PTR_WIDTH{1'b0}};
      rd_ptr_q <= {FIFO_PTR_WIDTH{1'b0}};
      occ_q    <= {CNT_W{1'b0}};
      pkt_q    <= {CNT_W{1'b0}};
      wcnt_q   <= {WCNT_W{1'b0}};
      tmo_q    <= {TMO_W{1'b0}};
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // Word storage, cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {wr_sop_s, wr_eop_s, rd_data};
    end
  end

endmodule

// File: doc/egress_packet_buffer.md
Name: egress_packet_buffer

Overview:
- Store-and-forward output buffer directly downstream of read_arbiter.
- Issues the one-cycle `ready` start pulse to the arbiter, but only when a maximum-length packet is guaranteed to fit.
- Captures the arbiter's rd_sop/rd_vld/rd_eop/rd_data stream into a word FIFO and releases whole packets to the egress port over a valid/ready handshake.
- Packets are never released before their last word has been stored.

Parameters:
- arbiter_data_width, 64, width of data words.
- fifo_depth, 32, number of FIFO word entries; power of two.
- fifo_ptr_width, 5, log2(fifo_depth).
- max_packet_words, 16, longest legal packet; also the free-space threshold for issuing `ready`.
- wait_timeout, 15, cycles to wait for rd_sop after `ready` before abandoning the request.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_data  input  arbiter_data_width  data word from the arbiter.
- rd_sop  input  1  first word of a packet; qualified by rd_vld.
- rd_vld  input  1  rd_data is valid this cycle.
- rd_eop  input  1  last word of a packet; qualified by rd_vld.
- ready  output  1  one-cycle pulse asking the arbiter to start one packet.
- out_data  output  arbiter_data_width  word at the FIFO head.
- out_sop  output  1  head word is the first word of a packet.
- out_eop  output  1  head word is the last word of a packet.
- out_vld  output  1  head word belongs to a completely stored packet.
- out_ready  input  1  egress accepts the word this cycle.
- pkt_count  output  fifo_ptr_width+1  number of complete packets stored.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - Write pointer, read pointer, occupancy, pkt_count, word counter and timeout counter go to 0.
  - ready=0, out_vld=0, err=0; out_sop, out_eop and out_data read 0.
  - Reset asserted mid-packet discards all stored and in-flight data.
- FIFO entry: {sop, eop, data}.
  - Occupancy counter ranges 0..fifo_depth.
  - free = fifo_depth - occupancy.
  - Pointers wrap modulo fifo_depth.
- IDLE → REQ: when free >= max_packet_words. Otherwise stay in IDLE.
- REQ:
  - ready=1 for exactly one cycle, then go to WAIT_SOP.
  - Timeout counter clears on entry to WAIT_SOP.
- WAIT_SOP:
  - rd_vld & rd_sop: write the word and clear the word counter to 1.
    - If rd_eop is also 1 (single-word packet), pkt_count increments and the FSM returns to IDLE.
    - Otherwise go to RECV.
  - rd_vld without rd_sop: word dropped, err set, stay in WAIT_SOP.
  - Timeout counter reaches wait_timeout with no sop: return to IDLE with no write (empty grant).
- RECV, words are written only on cycles with rd_vld=1:
  - rd_vld & rd_eop: write the word; pkt_count increments; go to IDLE.
  - Otherwise write the word and increment the word counter.
  - Word counter reaches max_packet_words-1 and the incoming word is not eop: store it with eop forced to 1, count the packet, set err, go to DROP.
  - rd_vld & rd_sop in RECV: the word is written as a normal data word with its stored sop bit forced to 0, and err is set.
- DROP: discard all words up to and including the rd_vld & rd_eop word, then go to IDLE.
- Read side:
  - out_data, out_sop and out_eop are taken from mem[rd_ptr], combinationally from the pointer.
  - out_vld = (pkt_count != 0).
  - A word is transferred when out_vld & out_ready; rd_ptr advances and occupancy decrements.
  - A transferred word with eop=1 decrements pkt_count.
- Latency: a packet whose eop word is written at edge N presents out_vld=1 after edge N, provided it is at the head.
- Simultaneous events:
  - A write and a read in the same cycle leave occupancy unchanged.
  - An eop write and an eop read in the same cycle leave pkt_count unchanged.
- Full: the FIFO cannot overflow, because the free-space check guarantees room before `ready` and DROP caps packet length.
- Stalling: out_ready=0 holds all out_* signals stable.
- err clears only on reset.

Test Plan:
- Reset, with FIFO empty: ready pulses 1 cycle on the 2nd edge after reset release. Arbiter returns sop, 4 middle words, eop (6 words, data 0x11..0x66). Expected: pkt_count goes 0→1 after the eop edge; with out_ready=1 the egress sees 6 words, out_sop on word 0x11, out_eop on 0x66; pkt_count returns to 0.
- Store-and-forward: out_ready=1 throughout, rd_vld gap of 3 cycles mid-packet. Expected: out_vld stays 0 until after the eop edge and no word leaves early.
- Backpressure: out_ready=0, three 6-word packets accepted (occupancy 18, free 14 < 16). Expected: no further ready pulse. Raise out_ready: after 2 words are read (free=16), a ready pulse occurs.
- Timeout: ready pulse with no rd_vld for 15 cycles. Expected: FSM back to IDLE, then a new ready pulse; FIFO and err unchanged.
- Overlength: 20-word packet. Expected: 16 words stored, the 16th with out_eop=1; err=1; words 17–20 discarded; pkt_count=1.
- Wrap and mid-operation reset: 40 consecutive 5-word packets with out_ready=1. Expected: data order preserved across pointer wrap. Then assert rst low mid-packet: expected out_vld=0, pkt_count=0, ready=0 immediately (asynchronous).
